// File: rtl/axi_xbar_remap_ctrl.sv
// Quiesces the crossbar's AW/AR slave-port handshakes, drains outstanding
// transactions, then atomically swaps the address map and default-port settings.
module axi_xbar_remap_ctrl #(
    parameter int unsigned NoSlvPorts  = 4,
    parameter int unsigned NoMstPorts  = 4,
    parameter int unsigned NoAddrRules = 4,
    // Same packed layout as axi_pkg::xbar_rule_64_t: {idx[31:0], start[63:0], end[63:0]}
    parameter type         rule_t      = logic [159:0],
    parameter int unsigned MaxTxns     = 8,
    localparam int unsigned DW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned CW = $clog2(MaxTxns + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NoSlvPorts-1:0]                slv_aw_valid_i,
    output logic [NoSlvPorts-1:0]                slv_aw_ready_o,
    output logic [NoSlvPorts-1:0]                xbar_aw_valid_o,
    input  logic [NoSlvPorts-1:0]                xbar_aw_ready_i,
    input  logic [NoSlvPorts-1:0]                slv_ar_valid_i,
    output logic [NoSlvPorts-1:0]                slv_ar_ready_o,
    output logic [NoSlvPorts-1:0]                xbar_ar_valid_o,
    input  logic [NoSlvPorts-1:0]                xbar_ar_ready_i,
    input  logic [NoSlvPorts-1:0]                b_valid_i,
    input  logic [NoSlvPorts-1:0]                b_ready_i,
    input  logic [NoSlvPorts-1:0]                r_valid_i,
    input  logic [NoSlvPorts-1:0]                r_ready_i,
    input  logic [NoSlvPorts-1:0]                r_last_i,
    input  logic                                 cfg_valid_i,
    output logic                                 cfg_ready_o,
    input  rule_t [NoAddrRules-1:0]              cfg_addr_map_i,
    input  logic [NoSlvPorts-1:0]                cfg_en_default_i,
    input  logic [NoSlvPorts-1:0][DW-1:0]        cfg_default_port_i,
    output rule_t [NoAddrRules-1:0]              addr_map_o,
    output logic [NoSlvPorts-1:0]                en_default_mst_port_o,
    output logic [NoSlvPorts-1:0][DW-1:0]        default_mst_port_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    typedef enum logic [1:0] {IDLE, BLOCK, DRAIN, SWAP} state_e;

    state_e                          state_q, state_d;
    logic [NoSlvPorts-1:0]           blk_aw_q, blk_aw_d, blk_ar_q, blk_ar_d;
    logic [NoSlvPorts-1:0][CW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    rule_t [NoAddrRules-1:0]         map_q, map_sh_q;
    logic [NoSlvPorts-1:0]           en_q, en_sh_q;
    logic [NoSlvPorts-1:0][DW-1:0]   dp_q, dp_sh_q;

    logic [NoSlvPorts-1:0] aw_hs, ar_hs, b_hs, r_hs;
    logic                  accept, gate_phase;

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
        logic [CW-1:0] res;
        res = cnt;
        if (inc && !dec && (cnt != CW'(MaxTxns))) begin
            res = cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - 1'b1;
        end
        return res;
    endfunction

    assign xbar_aw_valid_o = slv_aw_valid_i & ~blk_aw_q;
    assign slv_aw_ready_o  = xbar_aw_ready_i & ~blk_aw_q;
    assign xbar_ar_valid_o = slv_ar_valid_i & ~blk_ar_q;
    assign slv_ar_ready_o  = xbar_ar_ready_i & ~blk_ar_q;

    assign aw_hs = xbar_aw_valid_o & xbar_aw_ready_i;
    assign ar_hs = xbar_ar_valid_o & xbar_ar_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;
    assign r_hs  = r_valid_i & r_ready_i & r_last_i;

    assign accept     = (state_q == IDLE) && cfg_valid_i;
    assign gate_phase = (state_q == BLOCK) || (state_q == DRAIN);

    assign addr_map_o            = map_q;
    assign en_default_mst_port_o = en_q;
    assign default_mst_port_o    = dp_q;

    // A flag only closes once its port has no valid waiting on the crossbar.
    always_comb begin
        blk_aw_d = blk_aw_q;
        blk_ar_d = blk_ar_q;
        if (state_q == SWAP) begin
            blk_aw_d = '0;
            blk_ar_d = '0;
        end else if (gate_phase) begin
            blk_aw_d = blk_aw_q | ~slv_aw_valid_i | xbar_aw_ready_i;
            blk_ar_d = blk_ar_q | ~slv_ar_valid_i | xbar_ar_ready_i;
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        for (int i = 0; i < NoSlvPorts; i++) begin
            wr_cnt_d[i] = cnt_next(wr_cnt_q[i], aw_hs[i], b_hs[i]);
            rd_cnt_d[i] = cnt_next(rd_cnt_q[i], ar_hs[i], r_hs[i]);
        end
    end

    // BLOCK looks at next-cycle flags so an idle crossbar advances every cycle.
    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) state_d = BLOCK;
            end
            BLOCK: begin
                if (&{blk_aw_d, blk_ar_d}) state_d = DRAIN;
            end
            DRAIN: begin
                if (&{blk_aw_q, blk_ar_q} && (wr_cnt_q == '0) && (rd_cnt_q == '0)) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            blk_aw_q <= '0;
            blk_ar_q <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            map_q    <= '0;
            en_q     <= '0;
            dp_q     <= '0;
        end else begin
            state_q  <= state_d;
            blk_aw_q <= blk_aw_d;
            blk_ar_q <= blk_ar_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if (state_q == SWAP) begin
                map_q <= map_sh_q;
                en_q  <= en_sh_q;
                dp_q  <= dp_sh_q;
            end
        end
    end

    // Shadow holds the pending config; it is only ever read in SWAP.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            map_sh_q <= cfg_addr_map_i;
            en_sh_q  <= cfg_en_default_i;
            dp_sh_q  <= cfg_default_port_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NoSlvPorts; i++) begin
                assert (!(aw_hs[i] && !b_hs[i] && (wr_cnt_q[i] == CW'(MaxTxns))));
                assert (!(b_hs[i] && !aw_hs[i] && (wr_cnt_q[i] == '0)));
                assert (!(ar_hs[i] && !r_hs[i] && (rd_cnt_q[i] == CW'(MaxTxns))));
                assert (!(r_hs[i] && !ar_hs[i] && (rd_cnt_q[i] == '0)));
            end
        end
    end

endmodule

// File: tb/tb_axi_xbar_remap_ctrl.sv
// Directed bench for axi_xbar_remap_ctrl: swap expectations are queued at
// request time and a negedge monitor checks each done_o pulse and the new map.
module tb_axi_xbar_remap_ctrl;
    localparam int N  = 4;
    localparam int DW = 2;
    localparam int R  = 4;
    typedef logic [159:0] rule_t;
    typedef rule_t [R-1:0] map_t;
    typedef logic [N-1:0][DW-1:0] dp_t;

    typedef struct packed {
        int          lo;
        int          hi;
        map_t        map;
        logic [N-1:0] en;
        dp_t         dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [N-1:0] slv_aw_valid = '0, slv_aw_ready, xbar_aw_valid, xbar_aw_ready = '0;
    logic [N-1:0] slv_ar_valid = '0, slv_ar_ready, xbar_ar_valid, xbar_ar_ready = '0;
    logic [N-1:0] b_valid = '0, b_ready = '0, r_valid = '0, r_ready = '0, r_last = '0;
    logic         cfg_valid = 1'b0, cfg_ready;
    map_t         cfg_map = '0;
    logic [N-1:0] cfg_en = '0;
    dp_t          cfg_dp = '0;
    map_t         map_o;
    logic [N-1:0] en_o;
    dp_t          dp_o;
    logic         busy, done;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   out_pending = 1'b0;

    axi_xbar_remap_ctrl #(
        .NoSlvPorts(N), .NoMstPorts(4), .NoAddrRules(R), .rule_t(rule_t), .MaxTxns(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
        .xbar_aw_valid_o(xbar_aw_valid), .xbar_aw_ready_i(xbar_aw_ready),
        .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready),
        .xbar_ar_valid_o(xbar_ar_valid), .xbar_ar_ready_i(xbar_ar_ready),
        .b_valid_i(b_valid), .b_ready_i(b_ready),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_addr_map_i(cfg_map), .cfg_en_default_i(cfg_en), .cfg_default_port_i(cfg_dp),
        .addr_map_o(map_o), .en_default_mst_port_o(en_o), .default_mst_port_o(dp_o),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic map_t mk_map(input int seed);
        map_t m;
        for (int i = 0; i < R; i++) begin
            m[i] = {32'(i), 64'(seed * 32'h10000 + i * 32'h1000),
                    64'(seed * 32'h10000 + i * 32'h1000 + 32'hfff)};
        end
        return m;
    endfunction

    // Monitor: every done_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_pending) begin
            out_pending = 1'b0;
            n_cmp++;
            if (map_o !== cur.map) begin
                n_fail++;
                $display("FAIL swap_map: got %h expected %h", map_o, cur.map);
            end
            check("swap_en", 64'(en_o), 64'(cur.en));
            check("swap_dp", 64'(dp_o), 64'(cur.dp));
        end
        if (done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                cur = exp_q.pop_front();
                n_done++;
                if (cyc < cur.lo || cyc > cur.hi) begin
                    n_fail++;
                    $display("FAIL done_timing: got cycle %0d expected %0d..%0d", cyc, cur.lo, cur.hi);
                end
                out_pending = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a config request in the current cycle t; returns in cycle t+1.
    task automatic request(input map_t m, input logic [N-1:0] en, input dp_t dp,
                           input int lo_off, input int hi_off, input bit expect_swap,
                           output int t);
        exp_t e;
        cfg_map = m; cfg_en = en; cfg_dp = dp; cfg_valid = 1'b1;
        t = cyc;
        #1;
        check("cfg_ready_at_accept", 64'(cfg_ready), 64'd1);
        if (expect_swap) begin
            e.lo = t + lo_off; e.hi = t + hi_off; e.map = m; e.en = en; e.dp = dp;
            exp_q.push_back(e);
        end
        tick();
        cfg_valid = 1'b0; cfg_map = ~m; cfg_en = ~en; cfg_dp = ~dp;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        if (n_done < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got %0d swaps expected %0d", n_done, target);
        end
        tick();
        tick();
    endtask

    initial begin
        int  t;
        dp_t dpv;

        // Reset state
        #1;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_en", 64'(en_o), 64'd0);
        check("rst_dp", 64'(dp_o), 64'd0);
        check("rst_map_zero", 64'(map_o == '0), 64'd1);
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // Test 1: idle config, fixed four-cycle latency
        dpv = '0; dpv[0] = 2'd2;
        request(mk_map(1), 4'b0001, dpv, 3, 3, 1'b1, t);
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (k == 1) check("t1_cfg_ready_busy", 64'(cfg_ready), 64'd0);
            if (k <= 3) check("t1_busy", 64'(busy), 64'd1);
            if (k == 3) check("t1_en_before_swap", 64'(en_o), 64'd0);
            if (k == 4) begin
                check("t1_busy_after", 64'(busy), 64'd0);
                check("t1_cfg_ready_after", 64'(cfg_ready), 64'd1);
            end
            tick();
        end
        wait_done(1, 10);

        // Test 2: pending AW held through BLOCK, then drained through B
        slv_aw_valid[0] = 1'b1; xbar_aw_ready[0] = 1'b0;
        dpv = {2'd1, 2'd3, 2'd0, 2'd2};
        request(mk_map(2), 4'b0010, dpv, 10, 11, 1'b1, t);
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) xbar_aw_ready[0] = 1'b1;
            if (k == 6) slv_aw_valid[0] = 1'b0;
            if (k == 7) slv_aw_valid[0] = 1'b1;
            if (k == 8) slv_aw_valid[0] = 1'b0;
            if (k == 9) begin b_valid[0] = 1'b1; b_ready[0] = 1'b1; end
            #1;
            if (k <= 5) check("t2_aw_valid_held", 64'(xbar_aw_valid[0]), 64'd1);
            if (k == 7) begin
                check("t2_aw_valid_blocked", 64'(xbar_aw_valid[0]), 64'd0);
                check("t2_aw_ready_blocked", 64'(slv_aw_ready[0]), 64'd0);
            end
            check("t2_busy", 64'(busy), 64'd1);
            tick();
        end
        b_valid = '0; b_ready = '0; xbar_aw_ready = '0;
        wait_done(2, 20);

        // Tests 3/4: three reads drained by r_last beats; new AR on port 1 held off
        for (int k = 0; k < 3; k++) begin
            slv_ar_valid[2] = 1'b1; xbar_ar_ready[2] = 1'b1;
            #1;
            check("t3_ar_pass_valid", 64'(xbar_ar_valid[2]), 64'd1);
            check("t3_ar_pass_ready", 64'(slv_ar_ready[2]), 64'd1);
            tick();
        end
        slv_ar_valid[2] = 1'b0; xbar_ar_ready[1] = 1'b1;
        request(mk_map(3), 4'b0100, '0, 9, 10, 1'b1, t);
        for (int k = 1; k <= 12; k++) begin
            slv_ar_valid[1] = (k >= 2 && k <= 11);
            r_valid[2] = (k >= 3 && k <= 8);
            r_ready[2] = (k >= 3 && k <= 8);
            r_last[2]  = (k == 4 || k == 6 || k == 8);
            r_valid[1] = (k == 12); r_ready[1] = (k == 12); r_last[1] = (k == 12);
            #1;
            if (k >= 2 && k <= 10) begin
                check("t4_ar_valid_blocked", 64'(xbar_ar_valid[1]), 64'd0);
                check("t4_ar_ready_blocked", 64'(slv_ar_ready[1]), 64'd0);
            end
            if (k == 11) begin
                check("t4_ar_valid_reopen", 64'(xbar_ar_valid[1]), 64'd1);
                check("t4_ar_ready_reopen", 64'(slv_ar_ready[1]), 64'd1);
            end
            tick();
        end
        r_valid = '0; r_ready = '0; r_last = '0; xbar_ar_ready = '0;
        wait_done(3, 5);

        // Test 5: simultaneous AW and B at wr_cnt=2 keeps the count at 2
        for (int k = 0; k < 3; k++) begin
            slv_aw_valid[3] = 1'b1; xbar_aw_ready[3] = 1'b1;
            b_valid[3] = (k == 2); b_ready[3] = (k == 2);
            tick();
        end
        slv_aw_valid[3] = 1'b0; b_valid = '0; b_ready = '0;
        dpv = {2'd3, 2'd3, 2'd3, 2'd3};
        request(mk_map(5), 4'b1000, dpv, 6, 7, 1'b1, t);
        for (int k = 1; k <= 6; k++) begin
            b_valid[3] = (k == 3 || k == 5); b_ready[3] = (k == 3 || k == 5);
            #1;
            check("t5_busy", 64'(busy), 64'd1);
            tick();
        end
        b_valid = '0; b_ready = '0; xbar_aw_ready = '0;
        wait_done(4, 20);

        // Test 6: async reset during DRAIN aborts the remap
        slv_aw_valid[0] = 1'b1; xbar_aw_ready[0] = 1'b1;
        tick();
        slv_aw_valid[0] = 1'b0; xbar_aw_ready[0] = 1'b0;
        request(mk_map(6), 4'b1010, dpv, 0, 0, 1'b0, t);
        tick();
        tick();
        check("t6_busy_drain", 64'(busy), 64'd1);
        rst_ni = 1'b0;
        slv_aw_valid[0] = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("t6_rst_en", 64'(en_o), 64'd0);
        check("t6_rst_dp", 64'(dp_o), 64'd0);
        check("t6_rst_map_zero", 64'(map_o == '0), 64'd1);
        check("t6_rst_gate_open", 64'(xbar_aw_valid[0]), 64'd1);
        rst_ni = 1'b1;
        tick();
        check("t6_cfg_ready_next", 64'(cfg_ready), 64'd1);
        check("t6_busy_next", 64'(busy), 64'd0);
        slv_aw_valid[0] = 1'b0;
        repeat (4) tick();

        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
